// File: rtl/multi_chan_pulse_counter.sv
// N-channel start/stop pulse counter. Each channel counts up or down within 0..MAX.
// Each channel can be cleared, stopped and loaded on its own, and pulses tc when it wraps or saturates.
module multi_chan_pulse_counter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int MAX        = 20,
  localparam int LCW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            start,
  input  logic [NUM_CH-1:0]            stop,
  input  logic [NUM_CH-1:0]            clear,
  input  logic [NUM_CH-1:0]            dir,
  input  logic                         sat_mode,
  input  logic                         load,
  input  logic [LCW-1:0]               load_ch,
  input  logic [DATA_WIDTH-1:0]        load_val,
  output logic [NUM_CH*DATA_WIDTH-1:0] count,
  output logic [NUM_CH-1:0]            running,
  output logic [NUM_CH-1:0]            tc
);

  localparam logic [DATA_WIDTH-1:0] MAX_V  = DATA_WIDTH'(MAX);
  localparam logic [DATA_WIDTH-1:0] ZERO_V = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONE_V  = DATA_WIDTH'(1);

  // One count step; returns {tc pulse, next count}.
  function automatic logic [DATA_WIDTH:0] step_f(input logic [DATA_WIDTH-1:0] cur,
                                                 input logic down,
                                                 input logic sat);
    logic [DATA_WIDTH-1:0] nxt;
    logic                  pulse;
    nxt   = cur;
    pulse = 1'b0;
    if (!down) begin
      if (cur < MAX_V) begin
        nxt   = cur + ONE_V;
        pulse = sat && (nxt == MAX_V);
      end else if (sat) begin
        nxt   = MAX_V;
        pulse = 1'b0;
      end else begin
        nxt   = ZERO_V;
        pulse = 1'b1;
      end
    end else begin
      if (cur > ZERO_V) begin
        nxt   = cur - ONE_V;
        pulse = sat && (nxt == ZERO_V);
      end else if (sat) begin
        nxt   = ZERO_V;
        pulse = 1'b0;
      end else begin
        nxt   = MAX_V;
        pulse = 1'b1;
      end
    end
    return {pulse, nxt};
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DATA_WIDTH-1:0] cnt_r, cnt_s, clamp_s;
    logic                  run_r, run_s, tc_r, tc_s, load_hit_s;

    // Indices >= NUM_CH never match any channel, so out-of-range loads fall away.
    assign load_hit_s = load && (load_ch == LCW'(i));
    assign clamp_s    = (load_val > MAX_V) ? MAX_V : load_val;

    // Next-state selection: clear > stop > load-hit > start > run > hold.
    always_comb begin
      cnt_s = cnt_r;
      run_s = run_r;
      tc_s  = 1'b0;
      if (clear[i]) begin
        cnt_s = ZERO_V;
        run_s = 1'b0;
      end else if (stop[i]) begin
        run_s = 1'b0;
      end else if (load_hit_s) begin
        cnt_s = clamp_s;
      end else if (start[i] || run_r) begin
        run_s         = 1'b1;
        {tc_s, cnt_s} = step_f(cnt_r, dir[i], sat_mode);
      end else begin
        cnt_s = cnt_r;
      end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_r <= ZERO_V;
        run_r <= 1'b0;
        tc_r  <= 1'b0;
      end else begin
        cnt_r <= cnt_s;
        run_r <= run_s;
        tc_r  <= tc_s;
      end
    end

    assign count[i*DATA_WIDTH +: DATA_WIDTH] = cnt_r;
    assign running[i]                        = run_r;
    assign tc[i]                             = tc_r;
  end

endmodule

// File: tb/tb_multi_chan_pulse_counter.sv
// Directed and random checks of multi_chan_pulse_counter (default build plus a 6-channel build).
module tb_multi_chan_pulse_counter;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int MX = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NC-1:0] start = '0, stop = '0, clear = '0, dir = '0;
  logic          sat_mode = 1'b0, load = 1'b0;
  logic [1:0]    load_ch = 2'd0;
  logic [DW-1:0] load_val = 8'd0;
  logic [NC*DW-1:0] count;
  logic [NC-1:0]    running, tc;

  logic [5:0]    z6 = 6'd0;
  logic          l6 = 1'b0;
  logic [2:0]    lch6 = 3'd0;
  logic [7:0]    lv6 = 8'd0;
  logic [47:0]   count6;
  logic [5:0]    running6, tc6;

  int total = 0;
  int bad   = 0;

  int m_cnt [NC];
  bit m_run [NC];
  bit m_tc  [NC];

  always #5 clk = ~clk;

  multi_chan_pulse_counter #(.DATA_WIDTH(DW), .NUM_CH(NC), .MAX(MX)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .dir(dir),
    .sat_mode(sat_mode), .load(load), .load_ch(load_ch), .load_val(load_val),
    .count(count), .running(running), .tc(tc));

  multi_chan_pulse_counter #(.DATA_WIDTH(8), .NUM_CH(6), .MAX(20)) dut6 (
    .clk(clk), .reset(reset), .start(z6), .stop(z6), .clear(z6), .dir(z6),
    .sat_mode(1'b0), .load(l6), .load_ch(lch6), .load_val(lv6),
    .count(count6), .running(running6), .tc(tc6));

  function automatic logic [7:0] ch(input int i);
    return count[i*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if (count !== 32'h0 || running !== 4'h0 || tc !== 4'h0) begin
      bad++; $display("FAIL reset_state count=%h run=%b tc=%b want 0", count, running, tc); end
    start = 4'b0001; tick(); start = 4'b0000;
    total++; if (count !== 32'h00000001 || running !== 4'b0001) begin
      bad++; $display("FAIL start_first_step count=%h run=%b want 00000001/0001", count, running); end
    for (int k = 2; k <= 4; k++) begin
      tick();
      total++; if (ch(0) !== 8'(k) || running !== 4'b0001 || count[31:8] !== 24'h0) begin
        bad++; $display("FAIL run_step%0d count=%h run=%b want ch0=%0d", k, count, running, k); end
    end
    #2 reset = 1'b1;
    #1;
    total++; if (count !== 32'h0 || running !== 4'h0 || tc !== 4'h0) begin
      bad++; $display("FAIL async_reset count=%h run=%b tc=%b want 0", count, running, tc); end
    reset = 1'b0;
    tick();
    total++; if (count !== 32'h0 || running !== 4'h0) begin
      bad++; $display("FAIL idle_after_reset count=%h run=%b want 0", count, running); end
  endtask

  task automatic test_up_wrap();
    sat_mode = 1'b0; dir = 4'b0000;
    load = 1'b1; load_ch = 2'd1; load_val = 8'd19; tick(); load = 1'b0;
    total++; if (count !== 32'h00001300 || running !== 4'b0000) begin
      bad++; $display("FAIL load19 count=%h run=%b want 00001300/0000", count, running); end
    start = 4'b0010; tick(); start = 4'b0000;
    total++; if (count !== 32'h00001400 || tc !== 4'b0000 || running !== 4'b0010) begin
      bad++; $display("FAIL up_to_max count=%h tc=%b run=%b want 00001400/0000/0010", count, tc, running); end
    tick();
    total++; if (count !== 32'h00000000 || tc !== 4'b0010) begin
      bad++; $display("FAIL wrap_to_zero count=%h tc=%b want 00000000/0010", count, tc); end
    tick();
    total++; if (count !== 32'h00000100 || tc !== 4'b0000) begin
      bad++; $display("FAIL after_wrap count=%h tc=%b want 00000100/0000", count, tc); end
    load = 1'b1; load_ch = 2'd1; load_val = 8'd200; tick(); load = 1'b0;
    total++; if (count !== 32'h00001400 || running !== 4'b0010 || tc !== 4'b0000) begin
      bad++; $display("FAIL load_clamp count=%h run=%b tc=%b want 00001400/0010/0000", count, running, tc); end
    stop = 4'b0010; tick(); stop = 4'b0000;
    total++; if (count !== 32'h00001400 || running !== 4'b0000) begin
      bad++; $display("FAIL stop_ch1 count=%h run=%b want 00001400/0000", count, running); end
  endtask

  task automatic test_down_sat();
    sat_mode = 1'b1; dir = 4'b0100;
    load = 1'b1; load_ch = 2'd2; load_val = 8'd2; tick(); load = 1'b0;
    start = 4'b0100; tick(); start = 4'b0000;
    total++; if (ch(2) !== 8'd1 || tc[2] !== 1'b0) begin
      bad++; $display("FAIL down_to_1 ch2=%0d tc=%b want 1/0", ch(2), tc[2]); end
    tick();
    total++; if (ch(2) !== 8'd0 || tc !== 4'b0100) begin
      bad++; $display("FAIL down_to_0_sat ch2=%0d tc=%b want 0/0100", ch(2), tc); end
    tick();
    total++; if (ch(2) !== 8'd0 || tc !== 4'b0000 || running[2] !== 1'b1) begin
      bad++; $display("FAIL sat_hold ch2=%0d tc=%b run=%b want 0/0000/1", ch(2), tc, running[2]); end
    sat_mode = 1'b0; tick();
    total++; if (ch(2) !== 8'd20 || tc !== 4'b0100) begin
      bad++; $display("FAIL down_wrap ch2=%0d tc=%b want 20/0100", ch(2), tc); end
    stop = 4'b0100; tick(); stop = 4'b0000; dir = 4'b0000;
    total++; if (ch(1) !== 8'd20 || running !== 4'b0000) begin
      bad++; $display("FAIL ch1_untouched ch1=%0d run=%b want 20/0000", ch(1), running); end
  endtask

  task automatic test_priority();
    sat_mode = 1'b0; dir = 4'b0000;
    load = 1'b1; load_ch = 2'd3; load_val = 8'd4; tick(); load = 1'b0;
    start = 4'b1000; tick(); start = 4'b0000;
    total++; if (ch(3) !== 8'd5 || running[3] !== 1'b1) begin
      bad++; $display("FAIL prio_setup ch3=%0d run=%b want 5/1", ch(3), running[3]); end
    start = 4'b1000; stop = 4'b1000; tick(); start = 4'b0000; stop = 4'b0000;
    total++; if (ch(3) !== 8'd5 || running[3] !== 1'b0) begin
      bad++; $display("FAIL stop_beats_start ch3=%0d run=%b want 5/0", ch(3), running[3]); end
    start = 4'b1000; tick();
    total++; if (ch(3) !== 8'd6 || running[3] !== 1'b1) begin
      bad++; $display("FAIL restart ch3=%0d run=%b want 6/1", ch(3), running[3]); end
    load = 1'b1; load_ch = 2'd3; load_val = 8'd9; tick(); load = 1'b0;
    total++; if (ch(3) !== 8'd9 || running[3] !== 1'b1 || tc[3] !== 1'b0) begin
      bad++; $display("FAIL load_beats_start ch3=%0d run=%b tc=%b want 9/1/0", ch(3), running[3], tc[3]); end
    clear = 4'b1000; tick(); clear = 4'b0000;
    total++; if (ch(3) !== 8'd0 || running[3] !== 1'b0) begin
      bad++; $display("FAIL clear_beats_start ch3=%0d run=%b want 0/0", ch(3), running[3]); end
    tick(); start = 4'b0000;
    stop = 4'b1000; tick(); stop = 4'b0000;
    tick(); tick(); tick();
    total++; if (ch(3) !== 8'd1 || running[3] !== 1'b0) begin
      bad++; $display("FAIL frozen_after_stop ch3=%0d run=%b want 1/0", ch(3), running[3]); end
  endtask

  task automatic test_concurrency();
    clear = 4'b1111; tick(); clear = 4'b0000;
    load = 1'b1; load_val = 8'd10;
    for (int c = 0; c < NC; c++) begin load_ch = 2'(c); tick(); end
    load = 1'b0;
    dir = 4'b0101; start = 4'b1111; tick(); start = 4'b0000;
    total++; if (count !== 32'h0B090B09 || running !== 4'b1111) begin
      bad++; $display("FAIL mixed_dir count=%h run=%b want 0B090B09/1111", count, running); end
    load = 1'b1; load_ch = 2'd3; load_val = 8'd3; tick(); load = 1'b0;
    total++; if (count !== 32'h03080C08 || running !== 4'b1111) begin
      bad++; $display("FAIL load_one_ch count=%h run=%b want 03080C08/1111", count, running); end
    tick();
    total++; if (count !== 32'h04070D07) begin
      bad++; $display("FAIL after_load_step count=%h want 04070D07", count); end
    stop = 4'b1111; tick(); stop = 4'b0000; dir = 4'b0000;
    l6 = 1'b1; lch6 = 3'd5; lv6 = 8'd7; tick();
    total++; if (count6 !== 48'h070000000000 || running6 !== 6'd0) begin
      bad++; $display("FAIL load_ch5 count6=%h want 070000000000", count6); end
    lch6 = 3'd6; lv6 = 8'd9; tick();
    lch6 = 3'd7; tick();
    total++; if (count6 !== 48'h070000000000) begin
      bad++; $display("FAIL load_out_of_range count6=%h want 070000000000", count6); end
    lch6 = 3'd0; lv6 = 8'd30; tick(); l6 = 1'b0;
    total++; if (count6 !== 48'h070000000014) begin
      bad++; $display("FAIL load6_clamp count6=%h want 070000000014", count6); end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NC; c++) begin
      if (clear[c]) begin
        m_cnt[c] = 0; m_run[c] = 0; m_tc[c] = 0;
      end else if (stop[c]) begin
        m_run[c] = 0; m_tc[c] = 0;
      end else if (load && int'(load_ch) == c) begin
        m_cnt[c] = (int'(load_val) > MX) ? MX : int'(load_val); m_tc[c] = 0;
      end else if (start[c] || m_run[c]) begin
        m_run[c] = 1; m_tc[c] = 0;
        if (dir[c] == 1'b0) begin
          if (m_cnt[c] == MX) begin
            if (!sat_mode) begin m_cnt[c] = 0; m_tc[c] = 1; end
          end else begin
            m_cnt[c] = m_cnt[c] + 1; m_tc[c] = sat_mode && (m_cnt[c] == MX);
          end
        end else begin
          if (m_cnt[c] == 0) begin
            if (!sat_mode) begin m_cnt[c] = MX; m_tc[c] = 1; end
          end else begin
            m_cnt[c] = m_cnt[c] - 1; m_tc[c] = sat_mode && (m_cnt[c] == 0);
          end
        end
      end else begin
        m_tc[c] = 0;
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ec;
    logic [3:0]  er, et;
    clear = 4'b1111; tick(); clear = 4'b0000;
    for (int c = 0; c < NC; c++) begin m_cnt[c] = 0; m_run[c] = 0; m_tc[c] = 0; end
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < NC; c++) begin
        start[c] = ($urandom_range(0, 3) == 0);
        stop[c]  = ($urandom_range(0, 7) == 0);
        clear[c] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 15) == 0) dir[c] = ~dir[c];
      end
      if ($urandom_range(0, 31) == 0) sat_mode = ~sat_mode;
      load     = ($urandom_range(0, 3) == 0);
      load_ch  = 2'($urandom_range(0, 3));
      load_val = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 22));
      model_edge();
      tick();
      for (int c = 0; c < NC; c++) begin
        ec[c*8 +: 8] = 8'(m_cnt[c]); er[c] = m_run[c]; et[c] = m_tc[c];
      end
      total++; if (count !== ec || running !== er || tc !== et) begin
        bad++; $display("FAIL random_cycle%0d count=%h run=%b tc=%b want %h/%b/%b",
                        n, count, running, tc, ec, er, et); end
    end
    start = '0; stop = '0; clear = '0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_priority();
    test_concurrency();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
